// File: rtl/tri_list_sequencer.sv
// Triangle list store and per-frame replayer for the transform pipeline.
// Define TRI_LIST_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module tri_list_sequencer #(
    parameter int WI    = 8,
    parameter int WF    = 8,
    parameter int DEPTH = 64,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          list_w,
    input  logic [2:0][2:0][WI+WF-1:0]    tri_in,
    input  logic                          list_clear,
    input  logic                          frame_start,
    output logic [2:0][2:0][WI+WF-1:0]    tri_out,
    output logic                          tri_valid,
    input  logic                          tri_ready,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          list_full,
    output logic [CW-1:0]                 tri_count
`ifdef TRI_LIST_FRAME_CNT_EN
    ,
    output logic [15:0]                   frame_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = 9 * (WI + WF);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_idx;
    logic [TW-1:0] r_rd;
    logic [TW-1:0] r_mem [DEPTH];

    logic          w_idle;
    logic          w_full;
    logic          w_clr;
    logic          w_wr;
    logic          w_last;
    logic [CW-1:0] w_count_nxt;

    assign w_idle = (r_state == S_IDLE);
    assign w_full = (r_count == CW'(DEPTH));
    assign w_clr  = w_idle && list_clear;
    assign w_wr   = w_idle && list_w && !list_clear && !w_full;
    assign w_last = (r_idx == (r_len - CW'(1)));

    // Count after this cycle's clear/write; frame_start snapshots this value.
    always_comb begin
        w_count_nxt = r_count;
        if (w_clr) begin
            w_count_nxt = '0;
        end else if (w_wr) begin
            w_count_nxt = r_count + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (w_wr) begin
            r_mem[r_count[AW-1:0]] <= tri_in;
        end
    end

    // Registered read kept reset-free so the array maps to block RAM.
    always_ff @(posedge Clk) begin
        if (r_state == S_FETCH) begin
            r_rd <= r_mem[r_idx[AW-1:0]];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_len   <= '0;
            r_idx   <= '0;
        end else begin
            r_count <= w_count_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_len   <= w_count_nxt;
                        r_idx   <= '0;
                        r_state <= (w_count_nxt == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (tri_ready) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + CW'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TRI_LIST_FRAME_CNT_EN
    logic [15:0] r_fcnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fcnt <= '0;
        end else if (r_state == S_DONE) begin
            r_fcnt <= r_fcnt + 16'd1;
        end
    end

    assign frame_cnt = r_fcnt;
`endif

    assign tri_valid  = (r_state == S_ISSUE);
    assign tri_out    = tri_valid ? r_rd : '0;
    assign frame_done = (r_state == S_DONE);
    assign busy       = !w_idle;
    assign list_full  = w_full;
    assign tri_count  = r_count;

endmodule
